// File: rtl/fitness_tracker.sv
// Step-pulse metric engine: counts steps, derives distance, F32 and high-activity seconds,
// and converts a once-per-second snapshot to packed BCD with a sequential double-dabble.
module fitness_tracker #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int STEP_W   = 20
) (
  input  logic        clk100MHz,
  input  logic        reset,
  input  logic        pulse,
  output logic [15:0] stepC_bcd,
  output logic [15:0] distance_bcd,
  output logic [15:0] f32_bcd,
  output logic [15:0] highAct_bcd,
  output logic        step_overflow,
  output logic        sec_tick
);

  localparam int SEC_W  = $clog2(CLK_FREQ);
  localparam int RATE_W = $clog2(CLK_FREQ + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

  logic [SEC_W-1:0]  sec_cnt_q;
  logic              pulse_q;
  logic              step;
  logic [RATE_W-1:0] rate_q;
  logic [RATE_W-1:0] rate_final;
  logic [STEP_W-1:0] raw_q, raw_d;
  logic [STEP_W-1:0] milesFull;
  logic [3:0]        sec_idx_q, sec_idx_d;
  logic [3:0]        f32_q, f32_d;
  logic [5:0]        run_q, run_d;
  logic [13:0]       high_q, high_d;
  logic              ovf_q;
  logic [13:0]       stepsSnap, milesSnap;

  state_t      state_q;
  logic [13:0] op0_q, op1_q, op2_q;
  logic        tenths_q;
  logic [13:0] bin_q;
  logic [15:0] bcd_q, bcdAdj, bcdNext;
  logic [3:0]  bitCnt_q;
  logic [1:0]  sel_q;
  logic [15:0] res0_q;
  logic [11:0] res1_q;
  logic [15:0] stepC_q, distance_q, f32Out_q, highAct_q;

  function automatic logic [13:0] satAdd(input logic [13:0] a, input logic [6:0] b);
    logic [14:0] s;
    s = {1'b0, a} + {8'b0, b};
    return (s > 15'd9999) ? 14'd9999 : s[13:0];
  endfunction

  assign step       = pulse & ~pulse_q;
  assign sec_tick   = (sec_cnt_q == SEC_W'(CLK_FREQ - 1));
  assign rate_final = rate_q + RATE_W'(step);

  always_comb begin
    raw_d     = raw_q;
    f32_d     = f32_q;
    sec_idx_d = sec_idx_q;
    run_d     = run_q;
    high_d    = high_q;
    if (step && (raw_q != '1)) raw_d = raw_q + STEP_W'(1);
    if (sec_tick) begin
      if (sec_idx_q < 4'd9) begin
        if (rate_final > RATE_W'(32)) f32_d = f32_q + 4'd1;
        sec_idx_d = sec_idx_q + 4'd1;
      end
      // A full minute of high activity credits all 60 seconds at once, then one per second
      if (rate_final >= RATE_W'(64)) begin
        if (run_q < 6'd59) begin
          run_d = run_q + 6'd1;
        end else if (run_q == 6'd59) begin
          run_d  = 6'd60;
          high_d = satAdd(high_q, 7'd60);
        end else begin
          high_d = satAdd(high_q, 7'd1);
        end
      end else begin
        run_d = 6'd0;
      end
    end
  end

  always_comb begin
    milesFull = raw_d >> 11;
    milesSnap = (milesFull > STEP_W'(999)) ? 14'd999 : milesFull[13:0];
    stepsSnap = (raw_d > STEP_W'(9999)) ? 14'd9999 : raw_d[13:0];
    bcdAdj    = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcdNext = {bcdAdj[14:0], bin_q[13]};
  end

  always_ff @(posedge clk100MHz or posedge reset) begin
    if (reset) begin
      sec_cnt_q <= '0;
      pulse_q   <= 1'b1;
      rate_q    <= '0;
      raw_q     <= '0;
      sec_idx_q <= '0;
      f32_q     <= '0;
      run_q     <= '0;
      high_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pulse_q   <= pulse;
      sec_cnt_q <= sec_tick ? '0 : sec_cnt_q + SEC_W'(1);
      rate_q    <= sec_tick ? '0 : rate_final;
      raw_q     <= raw_d;
      sec_idx_q <= sec_idx_d;
      f32_q     <= f32_d;
      run_q     <= run_d;
      high_q    <= high_d;
      ovf_q     <= (raw_d > STEP_W'(9999));
    end
  end

  // Snapshot on the tick, convert the three operands back to back, then publish together
  always_ff @(posedge clk100MHz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op0_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      tenths_q   <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      bitCnt_q   <= '0;
      sel_q      <= '0;
      res0_q     <= '0;
      res1_q     <= '0;
      stepC_q    <= '0;
      distance_q <= '0;
      f32Out_q   <= '0;
      highAct_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sec_tick) begin
            op0_q    <= stepsSnap;
            op1_q    <= milesSnap;
            op2_q    <= high_d;
            tenths_q <= raw_d[10];
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          sel_q    <= 2'd0;
          bcd_q    <= '0;
          bin_q    <= op0_q;
          bitCnt_q <= '0;
          state_q  <= SHIFT;
        end
        SHIFT: begin
          bcd_q    <= bcdNext;
          bin_q    <= {bin_q[12:0], 1'b0};
          bitCnt_q <= bitCnt_q + 4'd1;
          if (bitCnt_q == 4'd13) begin
            bitCnt_q <= '0;
            case (sel_q)
              2'd0: begin
                res0_q <= bcdNext;
                bcd_q  <= '0;
                bin_q  <= op1_q;
                sel_q  <= 2'd1;
              end
              2'd1: begin
                res1_q <= bcdNext[11:0];
                bcd_q  <= '0;
                bin_q  <= op2_q;
                sel_q  <= 2'd2;
              end
              default: state_q <= COMMIT;
            endcase
          end
        end
        COMMIT: begin
          stepC_q    <= res0_q;
          distance_q <= {res1_q, tenths_q ? 4'h5 : 4'h0};
          f32Out_q   <= {12'b0, f32_q};
          highAct_q  <= bcd_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stepC_bcd     = stepC_q;
  assign distance_bcd  = distance_q;
  assign f32_bcd       = f32Out_q;
  assign highAct_bcd   = highAct_q;
  assign step_overflow = ovf_q;

endmodule

// File: tb/tb_fitness_tracker.sv
// Directed bench for fitness_tracker with a 200-cycle second; steps are placed at the end
// of each second so that a rate of n always includes a step on the tick cycle.
module tb_fitness_tracker;

  localparam int CF = 200;

  logic        clk100MHz;
  logic        reset;
  logic        pulse;
  logic [15:0] stepC_bcd, distance_bcd, f32_bcd, highAct_bcd;
  logic        step_overflow, sec_tick;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rateSet  = 0;
  logic forceOn = 1'b0;
  int tickErr  = 0;
  int tickCnt  = 0;

  fitness_tracker #(.CLK_FREQ(CF), .STEP_W(20)) dut (
    .clk100MHz    (clk100MHz),
    .reset        (reset),
    .pulse        (pulse),
    .stepC_bcd    (stepC_bcd),
    .distance_bcd (distance_bcd),
    .f32_bcd      (f32_bcd),
    .highAct_bcd  (highAct_bcd),
    .step_overflow(step_overflow),
    .sec_tick     (sec_tick)
  );

  initial clk100MHz = 1'b0;
  always #5 clk100MHz = ~clk100MHz;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One call advances n cycles; rateSet steps land on the last odd cycles of each second
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      int j;
      j = cyc % CF;
      pulse = forceOn | ((j % 2 == 1) && (j >= CF - 2 * rateSet));
      if (sec_tick !== (j == CF - 1)) tickErr++;
      if (sec_tick === 1'b1) tickCnt++;
      @(posedge clk100MHz);
      #1;
      cyc++;
    end
  endtask

  task automatic applyReset(input logic pulseLevel);
    reset   = 1'b1;
    pulse   = pulseLevel;
    forceOn = 1'b0;
    rateSet = 0;
    repeat (3) @(posedge clk100MHz);
    #1;
    reset   = 1'b0;
    cyc     = 0;
    tickErr = 0;
    tickCnt = 0;
  endtask

  initial begin
    reset = 1'b1;
    pulse = 1'b0;

    // Idle device: reset state, tick cadence, outputs stay zero
    applyReset(1'b0);
    checkOutput("rst_stepC", 32'(stepC_bcd), 32'h0);
    checkOutput("rst_dist", 32'(distance_bcd), 32'h0);
    checkOutput("rst_f32", 32'(f32_bcd), 32'h0);
    checkOutput("rst_high", 32'(highAct_bcd), 32'h0);
    checkOutput("rst_ovf", 32'(step_overflow), 32'h0);
    checkOutput("rst_tick", 32'(sec_tick), 32'h0);
    applyStimulus(3 * CF + 45);
    checkOutput("idle_tick_pos", 32'(tickErr), 32'd0);
    checkOutput("idle_tick_cnt", 32'(tickCnt), 32'd3);
    checkOutput("idle_stepC", 32'(stepC_bcd), 32'h0);
    checkOutput("idle_f32", 32'(f32_bcd), 32'h0);
    checkOutput("idle_ovf", 32'(step_overflow), 32'h0);

    // 40 then 10 steps; commit latency around the second tick
    applyReset(1'b0);
    rateSet = 40;
    applyStimulus(CF);
    rateSet = 10;
    applyStimulus(CF);
    rateSet = 0;
    applyStimulus(43);
    checkOutput("lat_before", 32'(stepC_bcd), 32'h0040);
    applyStimulus(1);
    checkOutput("lat_after", 32'(stepC_bcd), 32'h0050);
    checkOutput("f32_two_sec", 32'(f32_bcd), 32'h0001);
    checkOutput("dist_zero", 32'(distance_bcd), 32'h0);

    // 3072 steps over 32 s at 96/s: 1.5 miles, F32 frozen at 9
    applyReset(1'b0);
    rateSet = 96;
    applyStimulus(32 * CF);
    rateSet = 0;
    applyStimulus(45);
    checkOutput("dist_1p5", 32'(distance_bcd), 32'h0015);
    checkOutput("steps_3072", 32'(stepC_bcd), 32'h3072);
    checkOutput("f32_frozen", 32'(f32_bcd), 32'h0009);
    checkOutput("high_under60", 32'(highAct_bcd), 32'h0);

    // High activity: 65 s, break, 59 s, then the 60th second credits a new minute
    applyReset(1'b0);
    rateSet = 70;
    applyStimulus(65 * CF);
    rateSet = 10;
    applyStimulus(45);
    checkOutput("high_65", 32'(highAct_bcd), 32'h0065);
    applyStimulus(5 * CF - 45);
    rateSet = 70;
    applyStimulus(45);
    checkOutput("high_break", 32'(highAct_bcd), 32'h0065);
    applyStimulus(59 * CF - 45);
    applyStimulus(45);
    checkOutput("high_59run", 32'(highAct_bcd), 32'h0065);
    applyStimulus(CF - 45);
    rateSet = 0;
    applyStimulus(45);
    checkOutput("high_125", 32'(highAct_bcd), 32'h0125);

    // 33rd step on the tick cycle, then saturation past 9999 steps
    applyReset(1'b0);
    rateSet = 33;
    applyStimulus(CF);
    rateSet = 100;
    applyStimulus(45);
    checkOutput("tickstep_f32", 32'(f32_bcd), 32'h0001);
    checkOutput("tickstep_steps", 32'(stepC_bcd), 32'h0033);
    checkOutput("ovf_low", 32'(step_overflow), 32'h0);
    applyStimulus(100 * CF - 45);
    rateSet = 0;
    applyStimulus(45);
    checkOutput("sat_steps", 32'(stepC_bcd), 32'h9999);
    checkOutput("ovf_high", 32'(step_overflow), 32'h1);

    // Reset during SHIFT clears outputs at once; held-high pulse not counted after release
    applyReset(1'b0);
    rateSet = 40;
    applyStimulus(CF);
    rateSet = 0;
    applyStimulus(45);
    checkOutput("pre_rst_steps", 32'(stepC_bcd), 32'h0040);
    checkOutput("pre_rst_f32", 32'(f32_bcd), 32'h0001);
    applyStimulus(2 * CF + 19 - cyc);
    reset = 1'b1;
    #1;
    checkOutput("midrst_steps", 32'(stepC_bcd), 32'h0);
    checkOutput("midrst_f32", 32'(f32_bcd), 32'h0);
    checkOutput("midrst_ovf", 32'(step_overflow), 32'h0);
    applyReset(1'b1);
    forceOn = 1'b1;
    applyStimulus(CF);
    forceOn = 1'b0;
    rateSet = 1;
    applyStimulus(45);
    checkOutput("held_high", 32'(stepC_bcd), 32'h0);
    applyStimulus(CF - 45);
    rateSet = 0;
    applyStimulus(45);
    checkOutput("regrip_step", 32'(stepC_bcd), 32'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
